// File: rtl/ne555ex_pulse_meter_pkg.sv
// ne555ex_pkg: shared types and constants for the NE555EX pulse meter.
//   - meter FSM state encoding (also exported on state_o for debug)
//   - byte-select codes for the 8-bit readout
//   - stability length used by the optional glitch filter
package ne555ex_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meter_state_e;

    // Readout byte select
    localparam logic [1:0] SEL_HIGH_LO = 2'd0;
    localparam logic [1:0] SEL_HIGH_HI = 2'd1;
    localparam logic [1:0] SEL_PER_LO  = 2'd2;
    localparam logic [1:0] SEL_PER_HI  = 2'd3;

    // Consecutive stable cycles before the filter accepts a new level
    localparam int FILT_STABLE = 3;

    // Pick one byte of a 16-bit zero-extended capture
    function automatic logic [7:0] capture_byte(input logic [15:0] v, input logic upper);
        return upper ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/ne555ex_pulse_meter_if.sv
// Readout/control bundle of the NE555EX pulse meter.
// master = controller side (drives enable/signal/clear/select),
// slave  = meter side (drives readout, valid strobe, flags, state).
interface ne555ex_pulse_meter_if;
    logic       ena_i;
    logic       sig_i;
    logic       clear_i;
    logic [1:0] sel_i;
    logic [7:0] rd_data_o;
    logic       meas_valid_o;
    logic       ovf_o;
    logic [1:0] state_o;

    modport master (
        output ena_i, sig_i, clear_i, sel_i,
        input  rd_data_o, meas_valid_o, ovf_o, state_o
    );

    modport slave (
        input  ena_i, sig_i, clear_i, sel_i,
        output rd_data_o, meas_valid_o, ovf_o, state_o
    );
endinterface

// File: rtl/ne555ex_edge_sync.sv
// ne555ex_edge_sync: brings the asynchronous timer output into the clk
// domain and produces single-cycle rise/fall strobes.
// Optional: define NE555EX_PULSE_METER_GLITCH_FILTER_EN to insert a
// stability filter between the synchroniser and the edge detector
// (level accepted after FILT_STABLE equal samples; strobe latency 5
// instead of 2, pulses shorter than FILT_STABLE are dropped).
module ne555ex_edge_sync
    import ne555ex_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic lvl;
    logic prev_q;

    // Two-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef NE555EX_PULSE_METER_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_STABLE);

    logic          lvl_q;
    logic [CW-1:0] cnt_q;

    // Count consecutive samples that disagree with the accepted level;
    // flip the level once FILT_STABLE of them are seen in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else if (sync2_q == lvl_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILT_STABLE - 1)) begin
            lvl_q <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2_q;
`endif

    // Previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= lvl;
    end

    // Both strobes share the same pipeline depth, so widths are unbiased
    assign rise_o =  lvl & ~prev_q;
    assign fall_o = ~lvl &  prev_q;

endmodule

// File: rtl/ne555ex_pulse_meter.sv
// ne555ex_pulse_meter: measures high time and period of a 1-bit signal
// in clk cycles, holds the last complete measurement and exposes it as
// bytes selected by sel_i. Overflow is flagged when a measurement would
// not fit in W bits.
// Optional glitch filter (in ne555ex_edge_sync): macro
// NE555EX_PULSE_METER_GLITCH_FILTER_EN.
module ne555ex_pulse_meter
    import ne555ex_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ne555ex_pulse_meter_if.slave bus
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic         rise_det;
    logic         fall_det;

    meter_state_e state_q;
    logic [W-1:0] per_cnt_q;
    logic [W-1:0] hi_cnt_q;
    logic [W-1:0] hi_len_q;
    logic [W-1:0] high_q;
    logic [W-1:0] period_q;
    logic         valid_q;
    logic         ovf_q;

    logic [W-1:0] per_cnt_d;
    logic [W-1:0] hi_cnt_d;
    logic [15:0]  high_ext;
    logic [15:0]  period_ext;

    ne555ex_edge_sync u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.sig_i),
        .rise_o (rise_det),
        .fall_o (fall_det)
    );

    // Running counters advanced by one; used while no edge terminates the phase
    always_comb begin
        per_cnt_d = per_cnt_q + 1'b1;
        hi_cnt_d  = hi_cnt_q + 1'b1;
    end

    // Meter FSM: counting, capture, overflow, enable and clear handling.
    // clear_i is applied last so it overrides a same-cycle capture/overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARMED;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            hi_len_q  <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.ena_i) begin
                state_q   <= ARMED;
                per_cnt_q <= '0;
                hi_cnt_q  <= '0;
                hi_len_q  <= '0;
            end else begin
                unique case (state_q)
                    ARMED: begin
                        // Fall edges are ignored: the partial pulse is discarded
                        if (rise_det) begin
                            state_q   <= MEAS_HIGH;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                        end
                    end
                    MEAS_HIGH: begin
                        if (per_cnt_q == CNT_MAX) begin
                            // A fall does not end the period, so it cannot save it
                            ovf_q     <= 1'b1;
                            state_q   <= ARMED;
                            per_cnt_q <= '0;
                            hi_cnt_q  <= '0;
                        end else if (fall_det) begin
                            hi_len_q  <= hi_cnt_q;
                            per_cnt_q <= per_cnt_d;
                            state_q   <= MEAS_LOW;
                        end else begin
                            per_cnt_q <= per_cnt_d;
                            hi_cnt_q  <= hi_cnt_d;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise_det) begin
                            // Capture and immediately start the next period
                            high_q    <= hi_len_q;
                            period_q  <= per_cnt_q;
                            valid_q   <= 1'b1;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                            state_q   <= MEAS_HIGH;
                        end else if (per_cnt_q == CNT_MAX) begin
                            ovf_q     <= 1'b1;
                            state_q   <= ARMED;
                            per_cnt_q <= '0;
                            hi_cnt_q  <= '0;
                        end else begin
                            per_cnt_q <= per_cnt_d;
                        end
                    end
                    default: begin
                        state_q   <= ARMED;
                        per_cnt_q <= '0;
                        hi_cnt_q  <= '0;
                    end
                endcase
            end
            if (bus.clear_i) begin
                high_q   <= '0;
                period_q <= '0;
                ovf_q    <= 1'b0;
                valid_q  <= 1'b0;
            end
        end
    end

    // Byte readout: captures zero-extended to 16 bits, then byte-selected
    always_comb begin
        high_ext   = 16'(high_q);
        period_ext = 16'(period_q);
        unique case (bus.sel_i)
            SEL_HIGH_LO: bus.rd_data_o = capture_byte(high_ext, 1'b0);
            SEL_HIGH_HI: bus.rd_data_o = capture_byte(high_ext, 1'b1);
            SEL_PER_LO:  bus.rd_data_o = capture_byte(period_ext, 1'b0);
            default:     bus.rd_data_o = capture_byte(period_ext, 1'b1);
        endcase
    end

    assign bus.meas_valid_o = valid_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_ne555ex_pulse_meter.sv
// Bench for ne555ex_pulse_meter: a W=16 and a W=8 instance share one
// stimulus stream. A timestamp-level reference model (rise/fall times of
// the delayed, optionally filtered input) predicts every output each cycle;
// directed checks cover the named scenarios.
module tb_ne555ex_pulse_meter;
    import ne555ex_pkg::*;

`ifdef NE555EX_PULSE_METER_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 4;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 3;
`endif
    localparam int NH = 8192;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig   = 1'b0;
    logic       ena   = 1'b0;
    logic       clr   = 1'b0;
    logic [1:0] sel   = 2'd0;

    always #5 clk = ~clk;

    ne555ex_pulse_meter_if if16();
    ne555ex_pulse_meter_if if8();

    assign if16.sig_i = sig;   assign if8.sig_i = sig;
    assign if16.ena_i = ena;   assign if8.ena_i = ena;
    assign if16.clear_i = clr; assign if8.clear_i = clr;
    assign if16.sel_i = sel;   assign if8.sel_i = sel;

    ne555ex_pulse_meter #(.W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    ne555ex_pulse_meter #(.W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Input history, one entry per cycle; h_f is the level the meter sees
    bit h_sig[NH], h_f[NH], h_ena[NH], h_clr[NH], h_rst[NH];
    int n = 8;

    // Model: state, time of last effective rise, high length, captures
    int m_st[2], m_tr[2], m_hl[2], m_hi[2], m_per[2];
    bit m_ovf[2], m_vld[2];

    int n_cmp = 0, n_bad = 0;
    int pulses16 = 0;

    logic       o_vld16, o_ovf16, o_vld8, o_ovf8;
    logic [1:0] o_st16, o_st8;
    logic [7:0] o_rd16, o_rd8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int c);
        int  maxv;
        bit  rise, fall;
        rise = h_f[c-LAT] && !h_f[c-LAT-1];
        fall = !h_f[c-LAT] && h_f[c-LAT-1];
        for (int i = 0; i < 2; i++) begin
            maxv = (i == 0) ? 65535 : 255;
            m_vld[i] = 1'b0;
            if (!h_rst[c]) begin
                m_st[i] = 0; m_hi[i] = 0; m_per[i] = 0; m_ovf[i] = 1'b0;
            end else if (h_rst[c-1]) begin
                if (!h_ena[c-1]) begin
                    m_st[i] = 0;
                end else if (m_st[i] == 0) begin
                    if (rise) begin m_st[i] = 1; m_tr[i] = c; end
                end else if (c - m_tr[i] == maxv && !(m_st[i] == 2 && rise)) begin
                    m_ovf[i] = 1'b1; m_st[i] = 0;
                end else if (m_st[i] == 1 && fall) begin
                    m_hl[i] = c - m_tr[i]; m_st[i] = 2;
                end else if (m_st[i] == 2 && rise) begin
                    m_hi[i] = m_hl[i]; m_per[i] = c - m_tr[i];
                    m_vld[i] = 1'b1; m_tr[i] = c; m_st[i] = 1;
                end
                if (h_clr[c-1]) begin
                    m_hi[i] = 0; m_per[i] = 0; m_ovf[i] = 1'b0; m_vld[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_dut(input int i, input logic v, input logic o,
                           input logic [1:0] st, input logic [7:0] rd);
        string      w;
        logic [15:0] hv, pv;
        logic [7:0]  e;
        w  = (i == 0) ? "w16" : "w8";
        hv = 16'(m_hi[i]);
        pv = 16'(m_per[i]);
        case (sel)
            SEL_HIGH_LO: e = hv[7:0];
            SEL_HIGH_HI: e = hv[15:8];
            SEL_PER_LO:  e = pv[7:0];
            default:     e = pv[15:8];
        endcase
        chk({w, " meas_valid"}, 32'(v), 32'(m_vld[i]));
        chk({w, " ovf"}, 32'(o), 32'(m_ovf[i]));
        chk({w, " state"}, 32'(st), 32'(m_st[i]));
        chk({w, " rd_data"}, 32'(rd), 32'(e));
    endtask

    // One clock cycle: drive inputs, step model, sample and compare at negedge
    task automatic cyc(input bit s, input bit e, input bit c, input logic [1:0] sl);
        sig = s; ena = e; clr = c; sel = sl;
        n++;
        h_sig[n] = s; h_ena[n] = e; h_clr[n] = c; h_rst[n] = rst_n;
        if (FILT)
            h_f[n] = (h_sig[n] == h_sig[n-1] && h_sig[n-1] == h_sig[n-2]) ? s : h_f[n-1];
        else
            h_f[n] = s;
        @(negedge clk);
        o_vld16 = if16.meas_valid_o; o_ovf16 = if16.ovf_o;
        o_st16  = if16.state_o;      o_rd16  = if16.rd_data_o;
        o_vld8  = if8.meas_valid_o;  o_ovf8  = if8.ovf_o;
        o_st8   = if8.state_o;       o_rd8   = if8.rd_data_o;
        if (o_vld16 === 1'b1) pulses16++;
        model_step(n);
        chk_dut(0, o_vld16, o_ovf16, o_st16, o_rd16);
        chk_dut(1, o_vld8, o_ovf8, o_st8, o_rd8);
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int h, input int l, input bit e);
        for (int j = 0; j < h; j++) cyc(1'b1, e, 1'b0, 2'($urandom_range(0, 3)));
        for (int j = 0; j < l; j++) cyc(1'b0, e, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, 2'(k % 4));
        chk("reset state", 32'(o_st16), 32'(0));
        chk("reset rd", 32'(o_rd16), 32'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);

        // Basic 5 high / 7 low
        pulses16 = 0;
        for (int r = 0; r < 6; r++) wave(5, 7, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO); chk("basic sel0", 32'(o_rd16), 32'h05);
        cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_HI); chk("basic sel1", 32'(o_rd16), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, SEL_PER_LO);  chk("basic sel2", 32'(o_rd16), 32'h0C);
        cyc(1'b0, 1'b1, 1'b0, SEL_PER_HI);  chk("basic sel3", 32'(o_rd16), 32'h00);
        chk("basic pulses", 32'(pulses16), 32'(5));

        // Disable while in MEAS_LOW
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, SEL_HIGH_LO);
        chk("disable state", 32'(o_st16), 32'(ARMED));
        chk("disable keep high", 32'(o_rd16), 32'h05);
        chk("disable no valid", 32'(o_vld16), 32'(0));
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);

        // First partial pulse discarded
        pulses16 = 0;
        for (int k = 0; k < LAT + 3; k++) cyc(1'b1, 1'b0, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        wave(6, 9, 1'b1);
        wave(6, 9, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO); chk("discard high", 32'(o_rd16), 32'd6);
        cyc(1'b0, 1'b1, 1'b0, SEL_PER_LO);  chk("discard period", 32'(o_rd16), 32'd15);
        chk("discard pulses", 32'(pulses16), 32'(1));

        // Clear in the same cycle as a capturing rise
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 5; j++) begin
                cyc(1'b1, 1'b1, (r == 2 && j == LAT - 1), SEL_HIGH_LO);
                if (r == 2 && j == LAT) begin
                    chk("collide valid16", 32'(o_vld16), 32'(0));
                    chk("collide valid8", 32'(o_vld8), 32'(0));
                    chk("collide high", 32'(o_rd16), 32'(0));
                end
            end
            for (int j = 0; j < 7; j++) cyc(1'b0, 1'b1, 1'b0, SEL_PER_LO);
        end

        // Randomized waveforms with occasional disables and clears
        for (int r = 0; r < 40; r++) begin
            int h, l;
            h = $urandom_range(1, 30);
            l = $urandom_range(1, 30);
            if ($urandom_range(0, 19) == 0) begin
                cyc(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
                cyc(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
            end
            for (int j = 0; j < h + l; j++)
                cyc(j < h, 1'b1, ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
        end

        // Overflow on the W=8 instance: one long high
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1, 1'b0, SEL_HIGH_LO);
        chk("ovf w8 flag", 32'(o_ovf8), 32'(1));
        chk("ovf w8 state", 32'(o_st8), 32'(ARMED));
        chk("ovf w16 flag", 32'(o_ovf16), 32'(0));
        chk("ovf w16 state", 32'(o_st16), 32'(MEAS_HIGH));
        cyc(1'b1, 1'b1, 1'b1, SEL_HIGH_LO);
        cyc(1'b1, 1'b1, 1'b0, SEL_HIGH_LO);
        chk("clr ovf", 32'(o_ovf8), 32'(0));
        chk("clr rd high", 32'(o_rd8), 32'(0));
        cyc(1'b1, 1'b1, 1'b0, SEL_PER_LO);
        chk("clr rd period", 32'(o_rd8), 32'(0));

        // Glitch-filter scenario (model-checked in both builds)
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        pulses16 = 0;
        for (int k = 0; k < 20; k++) cyc(k != 10, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 1'b1, 1'b0, (j == LAT + 2) ? SEL_PER_LO : SEL_HIGH_LO);
`ifdef NE555EX_PULSE_METER_GLITCH_FILTER_EN
            if (j == LAT + 1) chk("glitch high", 32'(o_rd16), 32'd20);
            if (j == LAT + 2) chk("glitch period", 32'(o_rd16), 32'd40);
`endif
        end
`ifdef NE555EX_PULSE_METER_GLITCH_FILTER_EN
        chk("glitch pulses", 32'(pulses16), 32'(1));
`endif
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, SEL_HIGH_LO);
        for (int j = 0; j < LAT + 3; j++) begin
            cyc(1'b1, 1'b1, 1'b0, (j == LAT + 2) ? SEL_PER_LO : SEL_HIGH_LO);
`ifdef NE555EX_PULSE_METER_GLITCH_FILTER_EN
            if (j == LAT + 1) chk("split high", 32'(o_rd16), 32'd9);
            if (j == LAT + 2) chk("split period", 32'(o_rd16), 32'd19);
`endif
        end

        // Reset in the middle of a measurement
        wave(4, 3, 1'b1);
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 1'b0, SEL_PER_LO);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, SEL_PER_LO);
        chk("midrst state", 32'(o_st16), 32'(ARMED));
        chk("midrst rd", 32'(o_rd16), 32'(0));
        for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 1'b0, SEL_PER_LO);
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) wave(5, 7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
